// File: rtl/hmmm_pkg.sv
// rtl/hmmm_pkg.sv - shared HMMM types, word width and I/O opcode helpers
package hmmm_pkg;

    localparam int HMMM_WORD_W = 16;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_WAIT_IN,
        IO_DELIVER
    } io_state_t;

    typedef logic [HMMM_WORD_W-1:0] instr_t;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_DIV,
        ALU_MOD,
        ALU_NEG
    } aluop_t;

    // READ is 0000_xxxx_0000_0001, WRITE is 0000_xxxx_0000_0010
    function automatic logic is_io_read(input instr_t instr);
        return (instr[15:12] == 4'h0) && (instr[7:0] == 8'h01);
    endfunction

    function automatic logic is_io_write(input instr_t instr);
        return (instr[15:12] == 4'h0) && (instr[7:0] == 8'h02);
    endfunction

endpackage

// File: rtl/hmmm_io_unit_if.sv
// rtl/hmmm_io_unit_if.sv - core request, input stream and output stream signals of the I/O unit
interface hmmm_io_unit_if
    import hmmm_pkg::*;
#(
    parameter int DATA_W = HMMM_WORD_W
);
    logic              req_read;
    logic              req_write;
    logic [DATA_W-1:0] wr_data;
    logic              stall;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  req_read, req_write, wr_data, in_valid, in_data, out_ready,
        output stall, rd_valid, rd_data, in_ready, out_valid, out_data
    );

    modport master (
        output req_read, req_write, wr_data, in_valid, in_data, out_ready,
        input  stall, rd_valid, rd_data, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/hmmm_io_fifo.sv
// rtl/hmmm_io_fifo.sv - power-of-two output FIFO with registered occupancy count
module hmmm_io_fifo
    import hmmm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = HMMM_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push_eff;
    logic             pop_eff;

    // full/empty come only from the registered count, so a pop never frees a slot combinationally
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push_eff} - {{AW{1'b0}}, pop_eff};
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hmmm_io_unit.sv
// rtl/hmmm_io_unit.sv - HMMM console READ/WRITE unit; HMMM_IO_STATS_EN adds stall_cycles/ovf_seen
module hmmm_io_unit
    import hmmm_pkg::*;
#(
    parameter int DATA_W    = HMMM_WORD_W,
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    hmmm_io_unit_if.slave io
`ifdef HMMM_IO_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [0:0]  ovf_seen
`endif
);
    io_state_t         state;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              in_ready_q;
    logic              stall_c;
    logic              in_fire;
    logic              write_ok;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign in_fire   = io.in_valid & in_ready_q;
    // READ wins over a simultaneous WRITE; WRITE outside IDLE is dropped
    assign write_ok  = (state == IO_IDLE) & io.req_write & ~io.req_read;
    assign fifo_push = write_ok & ~fifo_full;
    assign fifo_pop  = io.out_ready & ~fifo_empty;

    always_comb begin
        stall_c = 1'b0;
        if (!reset) begin
            case (state)
                IO_IDLE:    stall_c = io.req_read | (io.req_write & fifo_full);
                IO_WAIT_IN: stall_c = 1'b1;
                default:    stall_c = 1'b0;
            endcase
        end
    end

    // DELIVER always returns to IDLE so the still-asserted req_read cannot start a second read
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IO_IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            case (state)
                IO_IDLE: begin
                    rd_valid_q <= 1'b0;
                    if (io.req_read) begin
                        state      <= IO_WAIT_IN;
                        in_ready_q <= 1'b1;
                    end
                end
                IO_WAIT_IN: begin
                    if (in_fire) begin
                        rd_data_q  <= io.in_data;
                        state      <= IO_DELIVER;
                        in_ready_q <= 1'b0;
                        rd_valid_q <= 1'b1;
                    end
                end
                IO_DELIVER: begin
                    state      <= IO_IDLE;
                    rd_valid_q <= 1'b0;
                end
                default: begin
                    state      <= IO_IDLE;
                    in_ready_q <= 1'b0;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    hmmm_io_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (io.wr_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign io.stall     = stall_c;
    assign io.rd_valid  = rd_valid_q;
    assign io.rd_data   = rd_data_q;
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = ~fifo_empty;
    assign io.out_data  = fifo_head;

`ifdef HMMM_IO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            ovf_seen     <= 1'b0;
        end else begin
            if (stall_c && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (write_ok && fifo_full) begin
                ovf_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hmmm_io_unit.sv
// tb/tb_hmmm_io_unit.sv - directed bench with queue-based reference model for hmmm_io_unit
module tb_hmmm_io_unit;
    import hmmm_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hmmm_io_unit_if #(.DATA_W(16)) io();

`ifdef HMMM_IO_STATS_EN
    logic [15:0] stall_cycles;
    logic [0:0]  ovf_seen;
`endif

    hmmm_io_unit #(
        .DATA_W    (16),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io           (io)
`ifdef HMMM_IO_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .ovf_seen     (ovf_seen)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: output queue, read progress (0 none, 1 waiting for input, 2 delivering)
    logic [15:0] m_q[$];
    int          m_phase = 0;
    logic [15:0] m_rd    = '0;
    int          m_sc    = 0;
    bit          m_ovf   = 1'b0;

    always @(negedge clk) begin : model
        bit e_stall;
        int sz;
        sz = m_q.size();
        if (reset)             e_stall = 1'b0;
        else if (m_phase == 1) e_stall = 1'b1;
        else if (m_phase == 2) e_stall = 1'b0;
        else                   e_stall = io.req_read | (io.req_write & (sz == DEPTH));

        check("m_stall",     io.stall,     e_stall);
        check("m_in_ready",  io.in_ready,  m_phase == 1);
        check("m_rd_valid",  io.rd_valid,  m_phase == 2);
        check("m_rd_data",   io.rd_data,   m_rd);
        check("m_out_valid", io.out_valid, sz > 0);
        check("m_out_data",  io.out_data,  (sz > 0) ? m_q[0] : 16'h0);
`ifdef HMMM_IO_STATS_EN
        check("m_stall_cycles", stall_cycles, m_sc);
        check("m_ovf_seen",     ovf_seen,     m_ovf);
`endif
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_rd    = '0;
            m_sc    = 0;
            m_ovf   = 1'b0;
        end else begin
            if (e_stall && m_sc < 16'hFFFF) m_sc++;
            if (sz > 0 && io.out_ready) void'(m_q.pop_front());
            if (m_phase == 0 && io.req_write && !io.req_read) begin
                if (sz < DEPTH) m_q.push_back(io.wr_data);
                else            m_ovf = 1'b1;
            end
            if (m_phase == 0) begin
                if (io.req_read) m_phase = 1;
            end else if (m_phase == 1) begin
                if (io.in_valid) begin
                    m_rd    = io.in_data;
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] v);
        bit done;
        done         = 1'b0;
        io.req_write = 1'b1;
        io.wr_data   = v;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!io.stall) begin
                done = 1'b1;
                tick();
                break;
            end
            tick();
        end
        io.req_write = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout: value %0h still stalled after 20 cycles", v);
        end
    endtask

    initial begin
        reset        = 1'b1;
        io.req_read  = 1'b0;
        io.req_write = 1'b0;
        io.wr_data   = '0;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        @(negedge clk);
        check("rst_stall",     io.stall,     0);
        check("rst_rd_valid",  io.rd_valid,  0);
        check("rst_rd_data",   io.rd_data,   0);
        check("rst_in_ready",  io.in_ready,  0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_out_data",  io.out_data,  0);
        tick();
        reset = 1'b0;

        // READ with input arriving 3 cycles after the request
        io.req_read = 1'b1;
        @(negedge clk);
        check("rd_req_stall",    io.stall,    1);
        check("rd_req_in_ready", io.in_ready, 0);
        tick();
        @(negedge clk);
        check("rd_wait_in_ready", io.in_ready, 1);
        tick();
        tick();
        io.in_valid = 1'b1;
        io.in_data  = 16'h002A;
        @(negedge clk);
        check("rd_cap_stall", io.stall, 1);
        tick();
        io.in_valid = 1'b0;
        io.in_data  = '0;
        @(negedge clk);
        check("rd_dlv_valid", io.rd_valid, 1);
        check("rd_dlv_data",  io.rd_data,  16'h002A);
        check("rd_dlv_stall", io.stall,    0);
`ifdef HMMM_IO_STATS_EN
        check("rd_stall_cycles", stall_cycles, 4);
`endif
        tick();
        io.req_read = 1'b0;
        @(negedge clk);
        check("rd_idle_valid",    io.rd_valid, 0);
        check("rd_idle_in_ready", io.in_ready, 0);
        check("rd_idle_stall",    io.stall,    0);
        tick();

        // WRITE burst into a blocked output stream
        for (int i = 1; i <= 4; i++) begin
            io.req_write = 1'b1;
            io.wr_data   = 16'(i);
            @(negedge clk);
            check("wr_no_stall", io.stall, 0);
            tick();
        end
        io.wr_data   = 16'd5;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("wr_full_stall", io.stall,    1);
        check("wr_full_head",  io.out_data, 1);
        tick();
        io.out_ready = 1'b0;
        @(negedge clk);
        check("wr_after_pop_stall", io.stall, 0);
        tick();
        io.req_write = 1'b0;
        io.out_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            @(negedge clk);
            check("wr_drain", io.out_data, v);
            tick();
        end
        @(negedge clk);
        check("wr_drained", io.out_valid, 0);
`ifdef HMMM_IO_STATS_EN
        check("wr_ovf_seen", ovf_seen, 1);
`endif
        tick();
        io.out_ready = 1'b0;

        // simultaneous push and pop at count 2
        do_write(16'd8);
        do_write(16'd9);
        io.req_write = 1'b1;
        io.wr_data   = 16'd7;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("cc_head8",  io.out_data, 8);
        check("cc_stall",  io.stall,    0);
        tick();
        io.req_write = 1'b0;
        io.out_ready = 1'b0;
        @(negedge clk);
        check("cc_head9", io.out_data, 9);
        tick();
        io.out_ready = 1'b1;
        @(negedge clk);
        check("cc_pop9", io.out_data, 9);
        tick();
        @(negedge clk);
        check("cc_pop7", io.out_data, 7);
        tick();
        @(negedge clk);
        check("cc_empty", io.out_valid, 0);

        // ten pushes with an intermittent consumer to wrap the pointers
        for (int i = 0; i < 10; i++) begin
            io.out_ready = (i % 3) != 0;
            do_write(16'h0100 + 16'(i));
        end
        io.out_ready = 1'b1;
        for (int k = 0; k < 12 && io.out_valid; k++) tick();
        @(negedge clk);
        check("wrap_drained", io.out_valid, 0);
        tick();
        io.out_ready = 1'b0;

        // illegal READ+WRITE together: read proceeds, write ignored
        io.req_read  = 1'b1;
        io.req_write = 1'b1;
        io.wr_data   = 16'hDEAD;
        io.in_valid  = 1'b1;
        io.in_data   = 16'h1234;
        tick();
        tick();
        io.in_valid = 1'b0;
        @(negedge clk);
        check("both_rd_valid", io.rd_valid, 1);
        check("both_rd_data",  io.rd_data,  16'h1234);
        tick();
        io.req_read  = 1'b0;
        io.req_write = 1'b0;
        @(negedge clk);
        check("both_no_push", io.out_valid, 0);
`ifdef HMMM_IO_STATS_EN
        check("ovf_sticky", ovf_seen, 1);
`endif
        tick();

        // reset while waiting for input
        io.req_read = 1'b1;
        tick();
        @(negedge clk);
        check("mid_wait", io.in_ready, 1);
        tick();
        reset       = 1'b1;
        io.req_read = 1'b0;
        @(negedge clk);
        check("mid_rst_stall", io.stall, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_in_ready", io.in_ready, 0);
        check("mid_stall",    io.stall,    0);
        check("mid_rd_valid", io.rd_valid, 0);
        check("mid_rd_data",  io.rd_data,  0);
`ifdef HMMM_IO_STATS_EN
        check("mid_ovf_clear", ovf_seen,     0);
        check("mid_sc_clear",  stall_cycles, 0);
`endif
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
